// File: rtl/pulse_sync_pkg.sv
// Shared types and defaults for the pulse synchronizer family.
package pulse_sync_pkg;

    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop level synchronizer; q follows d two clk edges later.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pulse_sync_src.sv
// Source side of a toggle-based pulse synchronizer.
// Define HAND_CNT_EN for ack handshake, pending-pulse counting and overflow flag.
module pulse_sync_src
    import pulse_sync_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic             pulse_in,
`ifdef HAND_CNT_EN
    input  logic             ack,
`endif
    output logic             tq,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

`ifdef HAND_CNT_EN

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             tq_q, tq_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             ack_match;
    logic             issue;

    bit_sync_2ff u_ack_sync (
        .clk (clk_src),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );

    assign ack_match = (ack_s == tq_q);
    assign issue     = ack_match && ((pend_q != '0) || pulse_in);

    always_comb begin
        state_d = state_q;
        tq_d    = tq_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // ack_s is not looked at here, so a spurious ack cannot start anything
                if (pulse_in) begin
                    tq_d    = ~tq_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (issue) begin
                    // A same-cycle pulse_in replaces the issued one in the count
                    tq_d = ~tq_q;
                    if (!pulse_in) begin
                        pend_d = pend_q - PEND_ONE;
                    end
                end else if (ack_match) begin
                    state_d = IDLE;
                end else if (pulse_in) begin
                    if (pend_q != PEND_MAX) begin
                        pend_d = pend_q + PEND_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tq_q    <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tq_q    <= tq_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tq       = tq_q;
    assign busy     = (state_q == WAIT_ACK) || (pend_q != '0);
    assign pend_cnt = pend_q;
    assign overflow = ovf_q;

`else

    logic tq_q, tq_d;

    always_comb begin
        tq_d = tq_q ^ pulse_in;
    end

    always_ff @(posedge clk_src or posedge rst) begin
        if (rst) begin
            tq_q <= 1'b0;
        end else begin
            tq_q <= tq_d;
        end
    end

    assign tq       = tq_q;
    assign busy     = 1'b0;
    assign pend_cnt = '0;
    assign overflow = 1'b0;

`endif

endmodule

// File: tb/tb_pulse_sync_src.sv
// Directed scoreboard bench for pulse_sync_src; exercises the handshake build when HAND_CNT_EN is defined.
`timescale 1ns/1ps
module tb_pulse_sync_src;

    localparam int unsigned TB_CNT_W = 2;

    logic                clk_src  = 1'b0;
    logic                rst      = 1'b0;
    logic                pulse_in = 1'b0;
`ifdef HAND_CNT_EN
    logic                ack      = 1'b0;
`endif
    logic                tq;
    logic                busy;
    logic [TB_CNT_W-1:0] pend_cnt;
    logic                overflow;

    int   checks  = 0;
    int   errors  = 0;
    logic exp_q[$];
    logic exp_lvl = 1'b0;
    logic tq_prev = 1'b0;

    pulse_sync_src #(.CNT_W(TB_CNT_W)) dut (
        .clk_src  (clk_src),
        .rst      (rst),
        .pulse_in (pulse_in),
`ifdef HAND_CNT_EN
        .ack      (ack),
`endif
        .tq       (tq),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 clk_src = ~clk_src;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    // Every tq transition must match the next expected level, in order.
    task automatic monitor();
        logic e;
        forever begin
            @(negedge clk_src);
            if (rst) begin
                tq_prev = tq;
            end else if (tq !== tq_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tq_unexpected_toggle: got level %0b expected no transition at %0t", tq, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tq_toggle_order", int'(tq), int'(e));
                end
                tq_prev = tq;
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pulse_in = 1'b0;
`ifdef HAND_CNT_EN
        ack      = 1'b0;
`endif
        #1;
        exp_q.delete();
        exp_lvl = 1'b0;
        check("rst_tq",       int'(tq),       0);
        check("rst_busy",     int'(busy),     0);
        check("rst_pend_cnt", int'(pend_cnt), 0);
        check("rst_overflow", int'(overflow), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_pulse(input bit accepted);
        pulse_in = 1'b1;
        if (accepted) begin
            exp_lvl = ~exp_lvl;
            exp_q.push_back(exp_lvl);
        end
        tick();
        pulse_in = 1'b0;
    endtask

`ifdef HAND_CNT_EN
    task automatic give_ack();
        ack = tq;
        repeat (3) tick();
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        do_reset();

`ifdef HAND_CNT_EN
        // Single pulse with ack round trip
        repeat (2) tick();
        send_pulse(1'b1);
        check("single_tq",   int'(tq),   1);
        check("single_busy", int'(busy), 1);
        ack = 1'b1;
        repeat (2) tick();
        check("busy_until_ack_s", int'(busy), 1);
        tick();
        check("idle_after_ack", int'(busy), 0);

        // Spurious ack while idle
        ack = 1'b0;
        repeat (4) tick();
        check("spurious_busy", int'(busy), 0);
        check("spurious_tq",   int'(tq),   1);
        ack = 1'b1;
        repeat (3) tick();

        // Three queued behind one in flight
        send_pulse(1'b1);
        repeat (3) send_pulse(1'b1);
        check("queued_pend3", int'(pend_cnt), 3);
        check("queued_busy",  int'(busy),     1);
        for (int i = 0; i < 3; i++) begin
            give_ack();
            check("drain_pend", int'(pend_cnt), 2 - i);
            check("drain_tq",   int'(tq),       int'(exp_lvl ^ ((i % 2) == 0)));
        end
        give_ack();
        check("drain_idle", int'(busy), 0);

        // Pulse on the ack-match cycle with two pending
        send_pulse(1'b1);
        repeat (2) send_pulse(1'b1);
        check("simul_pre_pend", int'(pend_cnt), 2);
        ack = tq;
        repeat (2) tick();
        send_pulse(1'b1);
        check("simul_pend_kept", int'(pend_cnt), 2);
        check("simul_tq",        int'(tq),       1);
        repeat (2) give_ack();
        check("simul_drained", int'(pend_cnt), 0);
        give_ack();
        check("simul_idle", int'(busy), 0);

        // Saturation and dropped pulse
        send_pulse(1'b1);
        repeat (3) send_pulse(1'b1);
        check("sat_pend",    int'(pend_cnt), 3);
        check("sat_no_ovf",  int'(overflow), 0);
        send_pulse(1'b0);
        check("sat_pend_held", int'(pend_cnt), 3);
        check("sat_ovf",       int'(overflow), 1);
        repeat (4) give_ack();
        check("sat_idle",       int'(busy),     0);
        check("sat_ovf_sticky", int'(overflow), 1);

        // Reset mid-operation, then a fresh single pulse
        send_pulse(1'b1);
        repeat (2) send_pulse(1'b1);
        check("prerst_pend", int'(pend_cnt), 2);
        do_reset();
        send_pulse(1'b1);
        check("postrst_tq",   int'(tq),   1);
        check("postrst_busy", int'(busy), 1);
        ack = 1'b1;
        repeat (2) tick();
        check("postrst_busy_hold", int'(busy), 1);
        tick();
        check("postrst_idle", int'(busy), 0);
`else
        // Free-running toggle, one pulse every four cycles
        for (int i = 0; i < 7; i++) begin
            send_pulse(1'b1);
            check("nh_tq_latency", int'(tq),       int'(exp_lvl));
            check("nh_busy",       int'(busy),     0);
            check("nh_pend_cnt",   int'(pend_cnt), 0);
            check("nh_overflow",   int'(overflow), 0);
            repeat (3) begin
                tick();
                check("nh_tq_hold", int'(tq), int'(exp_lvl));
            end
        end
        check("nh_tq_before_rst", int'(tq), 1);
        do_reset();
        send_pulse(1'b1);
        check("nh_postrst_tq", int'(tq), 1);
`endif

        repeat (4) tick();
        check("all_toggles_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_sync_src.md
PULSE_SYNC_SRC -- requirements
Module: pulse_sync_src

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the pending-pulse counter.
REQ-002 SHALL have port clk_src  input  1  source-domain clock; the only clock in the block.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pulse_in  input  1  single-cycle event request, synchronous to clk_src.
REQ-005 SHALL have port ack  input  1  destination-domain level equal to the received toggle; asynchronous to clk_src; present only with HAND_CNT_EN.
REQ-006 SHALL have port tq  output  1  registered toggle level that crosses to the destination synchronizer.
REQ-007 SHALL have port busy  output  1  high while a toggle is unacknowledged or pulses are pending.
REQ-008 SHALL have port pend_cnt  output  CNT_W  number of accepted pulses not yet issued on tq.
REQ-009 SHALL have port overflow  output  1  sticky flag set when a pulse is dropped.

Function
REQ-010 tq SHALL be driven directly by a flop, with no combinational logic after it.
REQ-011 With HAND_CNT_EN, ack SHALL pass through a 2-flop synchronizer to give ack_s, which is valid 2 clk_src edges after ack changes.
REQ-012 The FSM SHALL have two states: IDLE (tq == ack_s, nothing outstanding) and WAIT_ACK (a toggle is in flight).
REQ-013 In IDLE, pulse_in=1 SHALL invert tq at the next edge (latency 1) and move the FSM to WAIT_ACK.
REQ-014 In WAIT_ACK, pulse_in=1 SHALL increment pend_cnt by 1.
REQ-015 In WAIT_ACK, when ack_s == tq and the issue condition (pend_cnt>0 or pulse_in) holds, the block SHALL invert tq and stay in WAIT_ACK.
REQ-016 In the REQ-015 case, pend_cnt SHALL decrement by 1, or stay unchanged if pulse_in is also high (simultaneous +1/-1).
REQ-017 In WAIT_ACK, when ack_s == tq and pend_cnt==0 and pulse_in==0, the FSM SHALL return to IDLE.
REQ-018 pend_cnt SHALL saturate at 2^CNT_W-1; a pulse_in that can be neither issued nor counted SHALL be dropped and SHALL set overflow.
REQ-019 overflow SHALL remain set until reset.
REQ-020 busy SHALL equal (state==WAIT_ACK) or (pend_cnt != 0), decoded from registers only.
REQ-021 Every accepted pulse SHALL produce exactly one tq transition, in acceptance order, with no merging.
REQ-022 ack_s changing while in IDLE (a spurious ack) SHALL be ignored.

Reset
REQ-023 Asserting rst SHALL immediately force tq=0, busy=0, pend_cnt=0, overflow=0, state=IDLE and both synchronizer flops to 0.
REQ-024 Reset asserted mid-operation SHALL discard all pending pulses; the destination end SHALL be reset in the same reset window so tq and ack realign at 0.
REQ-025 Deassertion of rst SHALL be synchronized externally; the block itself adds no reset synchronizer.

Configuration
REQ-026 Macro HAND_CNT_EN SHALL, when defined, compile in the ack port, the ack synchronizer, the FSM, pend_cnt and overflow with the behaviour of REQ-011..REQ-022.
REQ-027 Without HAND_CNT_EN, there SHALL be no ack port, and tq SHALL invert on every pulse_in with latency 1.
REQ-028 Without HAND_CNT_EN, busy, pend_cnt and overflow SHALL be tied to 0, and there SHALL be no flow control: the user must space pulses by at least 3 destination clocks.

Structure
REQ-029 Shared package pulse_sync_pkg SHALL hold the FSM state encoding (IDLE=0, WAIT_ACK=1) and the default CNT_W=4.
REQ-030 The ack synchronizer SHALL be the sub-module bit_sync_2ff (clk, rst, d, q), reusable by other CDC blocks.

Verification
REQ-031 Reset, then a single pulse_in at cycle 5 -> tq goes 0->1 at edge 6 and busy=1; ack returned high -> ack_s high 2 edges later, then IDLE and busy=0 on the next edge.
REQ-032 Three back-to-back pulse_in while WAIT_ACK -> pend_cnt=3; each ack match issues one tq toggle; 4 toggles total; pend_cnt 3->2->1->0.
REQ-033 CNT_W=2, 5 pulses while ack withheld -> pend_cnt saturates at 3 and overflow=1 on the dropped pulse; after acks, exactly 4 toggles.
REQ-034 pulse_in in the same cycle as an ack match with pend_cnt=2 -> a toggle is issued and pend_cnt stays 2.
REQ-035 rst asserted while pend_cnt=2 and WAIT_ACK -> all outputs 0 within the reset; after release a new pulse_in behaves as in REQ-031.
REQ-036 Build without HAND_CNT_EN, pulses every 4 cycles -> tq toggles 1 cycle after each pulse; busy, pend_cnt and overflow remain 0.
